// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-master coprocessor memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TURN   = 2'd3
  } arb_state_e;

  typedef enum logic {
    MASTER0 = 1'b0,
    MASTER1 = 1'b1
  } master_e;

endpackage

// File: rtl/memory_arbiter.sv
// Two-master round-robin arbiter for the shared coprocessor memory: registered
// grant/release handshake, combinational owner mux, read data broadcast.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int width           = 128,
  parameter int memory_size_log = 8,
  parameter int max_hold        = 64,
  parameter int hold_width      = $clog2(max_hold + 1)
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       in_m0_req,
  input  logic [memory_size_log-1:0] in_m0_address,
  input  logic [width-1:0]           in_m0_data,
  input  logic                       in_m0_read_en,
  input  logic                       in_m0_write_en,
  input  logic                       in_m1_req,
  input  logic [memory_size_log-1:0] in_m1_address,
  input  logic [width-1:0]           in_m1_data,
  input  logic                       in_m1_read_en,
  input  logic                       in_m1_write_en,
  output logic                       out_m0_grant,
  output logic                       out_m0_release,
  output logic                       out_m1_grant,
  output logic                       out_m1_release,
  output logic [memory_size_log-1:0] out_mem_address,
  output logic [width-1:0]           out_mem_data,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  input  logic [width-1:0]           in_mem_data,
  output logic [width-1:0]           out_rd_data,
  output logic                       out_busy
);

  localparam logic [hold_width-1:0] HOLD_MAX = hold_width'(max_hold);

  arb_state_e            state_q, state_d;
  master_e               last_owner_q, last_owner_d;
  logic [hold_width-1:0] hold_q, hold_d;
  logic                  grant0_q, grant0_d;
  logic                  grant1_q, grant1_d;
  logic                  release0_q, release0_d;
  logic                  release1_q, release1_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    unique case (state_q)
      IDLE, TURN: begin
        // On a tie the master that did not own last wins.
        if (in_m0_req && (!in_m1_req || last_owner_q == MASTER1)) begin
          state_d      = GRANT0;
          last_owner_d = MASTER0;
          hold_d       = '0;
        end else if (in_m1_req) begin
          state_d      = GRANT1;
          last_owner_d = MASTER1;
          hold_d       = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        if (!in_m0_req) state_d = TURN;
        else if (in_m1_req && hold_q != HOLD_MAX) hold_d = hold_q + hold_width'(1);
      end
      GRANT1: begin
        if (!in_m1_req) state_d = TURN;
        else if (in_m0_req && hold_q != HOLD_MAX) hold_d = hold_q + hold_width'(1);
      end
    endcase

    grant0_d   = (state_d == GRANT0);
    grant1_d   = (state_d == GRANT1);
    busy_d     = (state_d != IDLE);
    // Release is sticky for the rest of the tenure; a fresh grant starts it clear.
    release0_d = grant0_d && (release0_q || (in_m1_req && hold_d == HOLD_MAX));
    release1_d = grant1_d && (release1_q || (in_m0_req && hold_d == HOLD_MAX));
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q      <= IDLE;
      last_owner_q <= MASTER1;
      hold_q       <= '0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      release0_q   <= 1'b0;
      release1_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      release0_q   <= release0_d;
      release1_q   <= release1_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    out_mem_address  = '0;
    out_mem_data     = '0;
    out_mem_read_en  = 1'b0;
    out_mem_write_en = 1'b0;
    unique case (state_q)
      GRANT0: begin
        out_mem_address  = in_m0_address;
        out_mem_data     = in_m0_data;
        out_mem_read_en  = in_m0_read_en;
        out_mem_write_en = in_m0_write_en;
      end
      GRANT1: begin
        out_mem_address  = in_m1_address;
        out_mem_data     = in_m1_data;
        out_mem_read_en  = in_m1_read_en;
        out_mem_write_en = in_m1_write_en;
      end
      IDLE, TURN: ;
    endcase
  end

  assign out_m0_grant   = grant0_q;
  assign out_m1_grant   = grant1_q;
  assign out_m0_release = release0_q;
  assign out_m1_release = release1_q;
  assign out_busy       = busy_q;
  assign out_rd_data    = in_mem_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small registered-read memory model.
module tb_memory_arbiter;

  localparam int W  = 128;
  localparam int AW = 8;
  localparam logic [W-1:0] WORD4  = 128'hC0DE0004_C0DE0004_C0DE0004_C0DE0004;
  localparam logic [W-1:0] WORD16 = 128'hC0DE0010_C0DE0010_C0DE0010_C0DE0010;

  logic          in_clk = 1'b0;
  logic          in_reset;
  logic          in_m0_req, in_m1_req;
  logic [AW-1:0] in_m0_address, in_m1_address;
  logic [W-1:0]  in_m0_data, in_m1_data;
  logic          in_m0_read_en, in_m0_write_en, in_m1_read_en, in_m1_write_en;
  logic          out_m0_grant, out_m0_release, out_m1_grant, out_m1_release;
  logic [AW-1:0] out_mem_address;
  logic [W-1:0]  out_mem_data, in_mem_data, out_rd_data;
  logic          out_mem_read_en, out_mem_write_en, out_busy;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.width(W), .memory_size_log(AW), .max_hold(4)) dut (
    .in_clk(in_clk), .in_reset(in_reset),
    .in_m0_req(in_m0_req), .in_m0_address(in_m0_address), .in_m0_data(in_m0_data),
    .in_m0_read_en(in_m0_read_en), .in_m0_write_en(in_m0_write_en),
    .in_m1_req(in_m1_req), .in_m1_address(in_m1_address), .in_m1_data(in_m1_data),
    .in_m1_read_en(in_m1_read_en), .in_m1_write_en(in_m1_write_en),
    .out_m0_grant(out_m0_grant), .out_m0_release(out_m0_release),
    .out_m1_grant(out_m1_grant), .out_m1_release(out_m1_release),
    .out_mem_address(out_mem_address), .out_mem_data(out_mem_data),
    .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
    .in_mem_data(in_mem_data), .out_rd_data(out_rd_data), .out_busy(out_busy)
  );

  always #5 in_clk = ~in_clk;

  // Memory model: unwritten words read as {4{C0DE00,addr}}.
  logic [W-1:0] store [256];
  logic         written [256];
  logic [W-1:0] rd_q;

  function automatic logic [W-1:0] init_word(input logic [AW-1:0] a);
    return {4{24'hC0DE00, a}};
  endfunction

  always @(posedge in_clk) begin
    if (!in_reset) begin
      for (int i = 0; i < 256; i++) written[i] <= 1'b0;
    end else begin
      if (out_mem_write_en) begin
        store[out_mem_address]   <= out_mem_data;
        written[out_mem_address] <= 1'b1;
      end
      if (out_mem_read_en)
        rd_q <= written[out_mem_address] ? store[out_mem_address] : init_word(out_mem_address);
    end
  end
  assign in_mem_data = rd_q;

  task automatic step;
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_m0_req = 0; in_m0_address = '0; in_m0_data = '0; in_m0_read_en = 0; in_m0_write_en = 0;
    in_m1_req = 0; in_m1_address = '0; in_m1_data = '0; in_m1_read_en = 0; in_m1_write_en = 0;
  endtask

  task automatic test_reset;
    in_reset = 0;
    idle_inputs();
    repeat (2) step();
    checks++; if ({out_m0_grant, out_m1_grant} !== 2'b00) begin errors++; $display("FAIL reset_grants got %b exp 00", {out_m0_grant, out_m1_grant}); end
    checks++; if ({out_m0_release, out_m1_release} !== 2'b00) begin errors++; $display("FAIL reset_release got %b exp 00", {out_m0_release, out_m1_release}); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", out_busy); end
    checks++; if ({out_mem_read_en, out_mem_write_en} !== 2'b00) begin errors++; $display("FAIL reset_enables got %b exp 00", {out_mem_read_en, out_mem_write_en}); end
    in_reset = 1;
    in_m1_address = 8'h33; in_m1_data = '1; in_m1_write_en = 1;
    step();
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", out_busy); end
    checks++; if (out_mem_write_en !== 1'b0) begin errors++; $display("FAIL idle_we got %b exp 0", out_mem_write_en); end
    checks++; if (out_mem_address !== 8'h00) begin errors++; $display("FAIL idle_addr got %h exp 00", out_mem_address); end
    checks++; if (out_mem_data !== '0) begin errors++; $display("FAIL idle_data got %h exp 0", out_mem_data); end
    idle_inputs();
  endtask

  task automatic test_single;
    in_m1_req = 1; in_m1_read_en = 1; in_m1_address = 8'h04;
    step();
    checks++; if ({out_m0_grant, out_m1_grant} !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", {out_m0_grant, out_m1_grant}); end
    checks++; if (out_mem_address !== 8'h04) begin errors++; $display("FAIL single_addr got %h exp 04", out_mem_address); end
    checks++; if (out_mem_read_en !== 1'b1) begin errors++; $display("FAIL single_re got %b exp 1", out_mem_read_en); end
    checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", out_busy); end
    step();
    checks++; if (out_rd_data !== WORD4) begin errors++; $display("FAIL single_rdata got %h exp %h", out_rd_data, WORD4); end
    in_m1_req = 0; in_m1_read_en = 0;
    step();
    checks++; if ({out_m1_grant, out_busy, out_mem_read_en} !== 3'b010) begin errors++; $display("FAIL single_turn got %b exp 010", {out_m1_grant, out_busy, out_mem_read_en}); end
    step();
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", out_busy); end
  endtask

  task automatic test_handoff;
    in_m0_req = 1;
    step();
    checks++; if ({out_m0_grant, out_m1_grant} !== 2'b10) begin errors++; $display("FAIL hand_g0 got %b exp 10", {out_m0_grant, out_m1_grant}); end
    in_m1_req = 1; in_m1_read_en = 1; in_m1_address = 8'h02;
    step();
    checks++; if ({out_m0_grant, out_m1_grant, out_mem_read_en} !== 3'b100) begin errors++; $display("FAIL hand_wait got %b exp 100", {out_m0_grant, out_m1_grant, out_mem_read_en}); end
    step();
    in_m0_req = 0;
    step();
    checks++; if ({out_m0_grant, out_m1_grant, out_busy} !== 3'b001) begin errors++; $display("FAIL hand_turn got %b exp 001", {out_m0_grant, out_m1_grant, out_busy}); end
    checks++; if ({out_mem_read_en, out_mem_write_en} !== 2'b00) begin errors++; $display("FAIL hand_turn_en got %b exp 00", {out_mem_read_en, out_mem_write_en}); end
    step();
    checks++; if ({out_m0_grant, out_m1_grant} !== 2'b01) begin errors++; $display("FAIL hand_g1 got %b exp 01", {out_m0_grant, out_m1_grant}); end
    checks++; if ({out_mem_address, out_mem_read_en} !== {8'h02, 1'b1}) begin errors++; $display("FAIL hand_mux got %h/%b exp 02/1", out_mem_address, out_mem_read_en); end
    idle_inputs();
    repeat (2) step();
  endtask

  task automatic test_round_robin;
    logic own;
    in_m0_req = 1; in_m1_req = 1;
    step();
    for (int r = 0; r < 4; r++) begin
      own = r[0];
      for (int c = 0; c < 3; c++) begin
        checks++; if ({out_m0_grant, out_m1_grant} !== {~own, own}) begin errors++; $display("FAIL rr_owner r%0d c%0d got %b exp %b", r, c, {out_m0_grant, out_m1_grant}, {~own, own}); end
        checks++; if ({out_m0_release, out_m1_release} !== 2'b00) begin errors++; $display("FAIL rr_release r%0d got %b exp 00", r, {out_m0_release, out_m1_release}); end
        if (c < 2) step();
      end
      if (own) in_m1_req = 0; else in_m0_req = 0;
      step();
      checks++; if ({out_m0_grant, out_m1_grant, out_busy} !== 3'b001) begin errors++; $display("FAIL rr_turn r%0d got %b exp 001", r, {out_m0_grant, out_m1_grant, out_busy}); end
      if (own) in_m1_req = 1; else in_m0_req = 1;
      step();
    end
    checks++; if ({out_m0_grant, out_m1_grant} !== 2'b10) begin errors++; $display("FAIL rr_wrap got %b exp 10", {out_m0_grant, out_m1_grant}); end
    idle_inputs();
    repeat (2) step();
  endtask

  task automatic test_hold_limit;
    in_m0_req = 1;
    step();
    in_m1_req = 1;
    repeat (3) step();
    checks++; if (out_m0_release !== 1'b0) begin errors++; $display("FAIL hold_early got %b exp 0", out_m0_release); end
    step();
    checks++; if (out_m0_release !== 1'b1) begin errors++; $display("FAIL hold_release got %b exp 1", out_m0_release); end
    checks++; if ({out_m0_grant, out_m1_grant} !== 2'b10) begin errors++; $display("FAIL hold_grant got %b exp 10", {out_m0_grant, out_m1_grant}); end
    repeat (3) step();
    checks++; if ({out_m0_grant, out_m0_release} !== 2'b11) begin errors++; $display("FAIL hold_persist got %b exp 11", {out_m0_grant, out_m0_release}); end
    in_m0_req = 0;
    step();
    checks++; if ({out_m0_grant, out_m0_release, out_m1_grant} !== 3'b000) begin errors++; $display("FAIL hold_drop got %b exp 000", {out_m0_grant, out_m0_release, out_m1_grant}); end
    step();
    checks++; if ({out_m1_grant, out_m1_release} !== 2'b10) begin errors++; $display("FAIL hold_next got %b exp 10", {out_m1_grant, out_m1_release}); end
    idle_inputs();
    repeat (2) step();
  endtask

  task automatic test_isolation;
    in_m0_req = 1; in_m0_address = 8'h10;
    step();
    in_m1_write_en = 1; in_m1_address = 8'h10; in_m1_data = '1;
    step();
    checks++; if (out_mem_write_en !== 1'b0) begin errors++; $display("FAIL iso_we got %b exp 0", out_mem_write_en); end
    checks++; if (out_mem_data !== '0) begin errors++; $display("FAIL iso_data got %h exp 0", out_mem_data); end
    step();
    in_m0_read_en = 1;
    step();
    checks++; if (out_rd_data !== WORD16) begin errors++; $display("FAIL iso_readback got %h exp %h", out_rd_data, WORD16); end
    idle_inputs();
    repeat (2) step();
  endtask

  task automatic test_reset_mid;
    in_m1_req = 1; in_m1_write_en = 1; in_m1_address = 8'h20; in_m1_data = 128'h5;
    step();
    checks++; if ({out_m1_grant, out_mem_write_en} !== 2'b11) begin errors++; $display("FAIL rmid_pre got %b exp 11", {out_m1_grant, out_mem_write_en}); end
    #2 in_reset = 0;
    #1;
    checks++; if ({out_m0_grant, out_m1_grant, out_busy} !== 3'b000) begin errors++; $display("FAIL rmid_async got %b exp 000", {out_m0_grant, out_m1_grant, out_busy}); end
    checks++; if ({out_m0_release, out_m1_release, out_mem_read_en, out_mem_write_en} !== 4'b0000) begin errors++; $display("FAIL rmid_outs got %b exp 0000", {out_m0_release, out_m1_release, out_mem_read_en, out_mem_write_en}); end
    in_m0_req = 1; in_m1_write_en = 0;
    step();
    checks++; if ({out_m0_grant, out_m1_grant} !== 2'b00) begin errors++; $display("FAIL rmid_held got %b exp 00", {out_m0_grant, out_m1_grant}); end
    in_reset = 1;
    step();
    checks++; if ({out_m0_grant, out_m1_grant} !== 2'b10) begin errors++; $display("FAIL rmid_tie got %b exp 10", {out_m0_grant, out_m1_grant}); end
    idle_inputs();
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_handoff();
    test_round_robin();
    test_hold_limit();
    test_isolation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-master arbiter for the shared coprocessor memory: master 0 is the host/loader path, master 1 is the `processor` request/grant port. It grants exclusive memory ownership using a registered request/grant handshake with round-robin tie-breaking. It routes the owner's address, data and enables to `memory` and broadcasts read data to both masters. A hold counter asks a long-running owner to release when the other master is waiting.

## Interface
Parameters:
- `width`, 128, memory data word width (cell_width × size).
- `memory_size_log`, 8, memory address width.
- `max_hold`, 64, owner cycles before release is requested while the other master waits; must be ≥1.
- `hold_width`, `$clog2(max_hold+1)`, hold counter width.

Ports:
- `in_clk`  in  1  single clock, rising edge.
- `in_reset`  in  1  asynchronous, active-low reset.
- `in_mN_req` (N=0,1)  in  1  master N requests or holds ownership.
- `in_mN_address`  in  memory_size_log  master N address.
- `in_mN_data`  in  width  master N write data.
- `in_mN_read_en`, `in_mN_write_en`  in  1  master N enables.
- `out_mN_grant`  out  1  master N owns memory.
- `out_mN_release`  out  1  master N is asked to drop its request.
- `out_mem_address`  out  memory_size_log  to memory.
- `out_mem_data`  out  width  to memory.
- `out_mem_read_en`, `out_mem_write_en`  out  1  to memory.
- `in_mem_data`  in  width  memory read data.
- `out_rd_data`  out  width  `in_mem_data`, passed through to both masters.
- `out_busy`  out  1  high in GRANT0, GRANT1 and TURN.

## Operation
- FSM states:
  - IDLE, GRANT0, GRANT1, TURN.
  - Reset state is IDLE, with `last_owner`=1 so that master 0 wins the first tie.
- Arbitration runs in IDLE and TURN:
  - Only one request: go to that master's GRANT.
  - Both requests: grant the master ≠ `last_owner`.
  - No request: go to or stay in IDLE.
- Entering GRANTn:
  - Set `last_owner`=n.
  - Clear the hold counter.
- In GRANTn:
  - Hold counter increments each cycle while the other master requests; it saturates at `max_hold`.
  - If the other master stops requesting, the counter holds its value and is not cleared.
  - When `in_mn_req` is low at a clock edge, go to TURN.
- `out_mn_grant` is registered and equals (state==GRANTn).
- `out_mn_release` is registered:
  - Set when the hold counter reaches `max_hold` with the other master requesting.
  - Cleared on leaving GRANTn.
  - Advisory only: the arbiter never revokes a grant. The owner must drop its request.
- Memory mux is combinational:
  - In GRANTn, `out_mem_*` take master n's address, data and enables.
  - In IDLE and TURN, enables are forced to 0; address and data are driven to 0.
  - Enables from a non-owner are ignored and never reach memory.
- `out_rd_data` = `in_mem_data` in every state.

## Timing
- Request to grant:
  - `in_mn_req` rises before edge k in IDLE → `out_mn_grant`=1 after edge k.
  - The owner's first access is issued in that cycle.
- Release:
  - Request low at edge k → grant low after edge k (TURN).
  - Earliest new grant is after edge k+1.
  - TURN always lasts exactly one cycle, which lets a read issued in the last owner cycle return data before the next owner drives memory.
- Back-to-back handoff: 1 dead cycle between owners.
- Simultaneous requests in IDLE or TURN: round-robin as above; never both grants.
- Owner keeps requesting past `max_hold`: grant persists; `out_mn_release` stays 1.
- Reset mid-operation:
  - All grant and release outputs, `out_busy`, and memory enables go to 0 immediately (asynchronously).
  - FSM returns to IDLE, `last_owner`=1, counter=0.
- All outputs reset to 0.

## Structure
- Shared package or header:
  - State encodings (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2, TURN=2'd3).
  - Master IDs.
- Single module, no sub-modules. A per-master mux would be trivial and is kept inline.

## Test plan
- Reset: drive `in_reset`=0 mid-GRANT1 → all grant, release and enable outputs are 0 immediately. Release reset with both requests high → master 0 is granted 1 cycle later.
- Single master: m1 requests and reads address 8'h04 → `out_m1_grant` next cycle, `out_mem_address`=8'h04, `out_mem_read_en`=1, and `out_rd_data` shows word 4 one cycle later.
- Handoff: m0 holds the grant while m1 requests. m0 drops at edge k → TURN after k, `out_m1_grant`=1 after k+1, and no enable is asserted in TURN.
- Round-robin: both masters request continuously, and each owner drops after 3 cycles → grants alternate 0,1,0,1 with exactly 1 TURN cycle between owners.
- Hold limit: `max_hold`=4, m0 owns and never drops, m1 requests → `out_m0_release`=1 after 4 cycles of m1 waiting. Grant is retained until m0 drops.
- Isolation: the non-owner asserts `write_en` to address 8'h10 with 128'hFF..FF → memory word 16 is unchanged on readback.
